// File: rtl/invaders_march_pkg.sv
// Shared game definitions: march FSM encoding, screen geometry and the step-interval helper.
// The renderer imports the same screen constants so both agree on the playfield.
package invaders_march_pkg;

    localparam int POS_W         = 10;
    localparam int SCREEN_X_MIN  = 0;
    localparam int SCREEN_X_MAX  = 400;
    localparam int SCREEN_Y_LAND = 400;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STEP   = 2'd2,
        S_LANDED = 2'd3
    } march_state_t;

    // Fewer survivors means a shorter interval, so the march speeds up as invaders die.
    function automatic logic [31:0] calc_interval(input logic [31:0] min_ticks,
                                                  input logic [31:0] per_alive,
                                                  input logic [5:0]  alive);
        logic [31:0] base;
        base = (min_ticks == 32'd0) ? 32'd1 : min_ticks;
        return base + ({26'd0, alive} * per_alive);
    endfunction

endpackage

// File: rtl/invaders_march.sv
// Invader block march controller: waits a survivor-dependent number of 1 us ticks,
// then steps the block sideways, or drops it a row and reverses it at a screen edge.
//
// state    | meaning
// S_IDLE   | parked at the start position until enabled
// S_WAIT   | counting ticks toward the latched interval
// S_STEP   | one-cycle position update
// S_LANDED | block reached the landing row; frozen until reset
module invaders_march
    import invaders_march_pkg::*;
#(
    parameter int X_START         = 16,
    parameter int Y_START         = 32,
    parameter int X_MIN           = SCREEN_X_MIN,
    parameter int X_MAX           = SCREEN_X_MAX,
    parameter int X_STEP          = 4,
    parameter int Y_STEP          = 8,
    parameter int Y_LAND          = SCREEN_Y_LAND,
    parameter int MIN_TICKS       = 1000,
    parameter int TICKS_PER_ALIVE = 500
) (
    input  logic             i_clk_36MHz,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic             i_enable,
    input  logic [5:0]       i_alive_count,
    output logic [POS_W-1:0] o_x,
    output logic [POS_W-1:0] o_y,
    output logic             o_dir,
    output logic             o_step,
    output logic             o_landed
);

    localparam logic [31:0]      X_MIN_W   = 32'(X_MIN);
    localparam logic [31:0]      X_MAX_W   = 32'(X_MAX);
    localparam logic [31:0]      X_STEP_W  = 32'(X_STEP);
    localparam logic [31:0]      Y_STEP_W  = 32'(Y_STEP);
    localparam logic [31:0]      Y_LAND_W  = 32'(Y_LAND);
    localparam logic [31:0]      MIN_W     = 32'(MIN_TICKS);
    localparam logic [31:0]      PER_W     = 32'(TICKS_PER_ALIVE);
    localparam logic [POS_W-1:0] X_START_P = POS_W'(X_START);
    localparam logic [POS_W-1:0] Y_START_P = POS_W'(Y_START);
    localparam logic [POS_W-1:0] X_STEP_P  = POS_W'(X_STEP);

    march_state_t     state;
    logic [31:0]      tick_cnt;
    logic [31:0]      interval;
    logic [31:0]      cnt_inc;
    logic [31:0]      y_sum;
    logic [POS_W-1:0] x_next;
    logic [POS_W-1:0] y_next;
    logic             dir_next;
    logic             land_next;

    assign cnt_inc = tick_cnt + 32'd1;
    assign y_sum   = 32'(o_y) + Y_STEP_W;

    // Edge tests are done 32 bits wide so the left edge check can never wrap below zero.
    always_comb begin
        x_next   = o_x;
        y_next   = o_y;
        dir_next = o_dir;
        if (o_dir) begin
            if (32'(o_x) + X_STEP_W > X_MAX_W) begin
                y_next   = POS_W'(y_sum);
                dir_next = 1'b0;
            end else begin
                x_next = o_x + X_STEP_P;
            end
        end else begin
            if (32'(o_x) < X_MIN_W + X_STEP_W) begin
                y_next   = POS_W'(y_sum);
                dir_next = 1'b1;
            end else begin
                x_next = o_x - X_STEP_P;
            end
        end
        land_next = (32'(y_next) >= Y_LAND_W);
    end

    always_ff @(posedge i_clk_36MHz) begin
        if (!i_reset) begin
            state    <= S_IDLE;
            tick_cnt <= 32'd0;
            interval <= 32'd0;
            o_x      <= X_START_P;
            o_y      <= Y_START_P;
            o_dir    <= 1'b1;
            o_step   <= 1'b0;
            o_landed <= 1'b0;
        end else begin
            o_step <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state    <= S_WAIT;
                        tick_cnt <= 32'd0;
                        interval <= calc_interval(MIN_W, PER_W, i_alive_count);
                    end
                end
                S_WAIT: begin
                    if (i_enable && i_tick) begin
                        tick_cnt <= cnt_inc;
                        if (cnt_inc >= interval) state <= S_STEP;
                    end
                end
                S_STEP: begin
                    o_x      <= x_next;
                    o_y      <= y_next;
                    o_dir    <= dir_next;
                    o_step   <= 1'b1;
                    tick_cnt <= 32'd0;
                    if (land_next) begin
                        state    <= S_LANDED;
                        o_landed <= 1'b1;
                    end else begin
                        state    <= S_WAIT;
                        interval <= calc_interval(MIN_W, PER_W, i_alive_count);
                    end
                end
                S_LANDED: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/invaders_march.md
INVADERS_MARCH -- requirements
Module: invaders_march

Interface
REQ-001 Parameter X_START, default 16: initial horizontal position of the invader block, in pixels.
REQ-002 Parameter Y_START, default 32: initial vertical position, in pixels.
REQ-003 Parameter X_MIN, default 0: leftmost allowed x.
REQ-004 Parameter X_MAX, default 400: rightmost allowed x.
REQ-005 Parameter X_STEP, default 4: horizontal move per step, in pixels.
REQ-006 Parameter Y_STEP, default 8: downward move on an edge hit, in pixels.
REQ-007 Parameter Y_LAND, default 400: y at or beyond which the invaders have landed.
REQ-008 Parameter MIN_TICKS, default 1000: base step interval, in i_tick pulses.
REQ-009 Parameter TICKS_PER_ALIVE, default 500: extra ticks added per surviving invader.
REQ-010 i_clk_36MHz  in  1  sole system clock, 36 MHz.
REQ-011 i_reset  in  1  synchronous, active-low reset.
REQ-012 i_tick  in  1  one-cycle pulse every 1 us, driven by the upstream 1 us timer.
REQ-013 i_enable  in  1  march enable; 0 pauses the march.
REQ-014 i_alive_count  in  6  number of invaders still alive, 0..55.
REQ-015 o_x  out  10  current block x.
REQ-016 o_y  out  10  current block y.
REQ-017 o_dir  out  1  march direction; 1 = right, 0 = left.
REQ-018 o_step  out  1  one-cycle pulse, asserted the cycle after each position update.
REQ-019 o_landed  out  1  sticky flag: the invaders have reached Y_LAND.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT, STEP and LANDED.
REQ-021 IDLE: when i_enable=1, the FSM SHALL go to WAIT, clear the tick counter and latch interval = MIN_TICKS + i_alive_count*TICKS_PER_ALIVE (32-bit, no overflow at the defaults).
REQ-022 i_alive_count=0 SHALL yield interval = MIN_TICKS; MIN_TICKS=0 SHALL be treated as 1.
REQ-023 WAIT with i_enable=1: each i_tick SHALL increment the counter; the tick that brings the counter to the interval SHALL move the FSM to STEP on the next edge.
REQ-024 WAIT with i_enable=0: the counter SHALL hold and i_tick SHALL be ignored; counting resumes unchanged when i_enable returns to 1.
REQ-025 STEP, rightward: if o_x + X_STEP > X_MAX, then o_y += Y_STEP and o_dir := 0 with o_x unchanged; otherwise o_x += X_STEP.
REQ-026 STEP, leftward: if o_x < X_MIN + X_STEP, then o_y += Y_STEP and o_dir := 1 with o_x unchanged; otherwise o_x -= X_STEP (never underflows).
REQ-027 STEP SHALL last exactly one cycle; an i_tick arriving during STEP SHALL be ignored.
REQ-028 o_step SHALL be registered and asserted for exactly one cycle, the cycle after STEP.
REQ-029 After STEP: if the new o_y >= Y_LAND, the FSM SHALL go to LANDED; otherwise it SHALL go to WAIT, clear the counter and re-latch the interval from the current i_alive_count.
REQ-030 A change of i_alive_count during WAIT SHALL NOT affect the current interval.
REQ-031 LANDED: o_landed=1 and all outputs frozen until reset; i_enable and i_tick SHALL be ignored.

Reset
REQ-032 With i_reset=0 at a clock edge: state=IDLE, counter=0, o_x=X_START, o_y=Y_START, o_dir=1, o_step=0, o_landed=0.
REQ-033 Reset SHALL take priority in every state, including mid-WAIT and STEP; the cycle after reset release SHALL behave as IDLE.
REQ-034 Initial values SHALL equal the reset values.

Structure
REQ-035 The state encoding and the shared screen constants (X_MIN, X_MAX, Y_LAND, position width of 10) SHALL live in a shared game package, reused by the renderer.
REQ-036 The block SHALL be a single module with no sub-module; the interval multiply is a constant multiply on 6 bits.

Verification (MIN_TICKS=2, TICKS_PER_ALIVE=1, X_START=8, X_MAX=16, X_MIN=0, X_STEP=4, Y_STEP=8, Y_START=0, Y_LAND=24)
REQ-037 alive=1, enable=1, i_tick every 36 clocks -> first o_step on the 3rd tick, o_x=12; 2nd step o_x=16.
REQ-038 Continue from o_x=16, dir right -> next step o_y=8, o_dir=0, o_x=16; following step o_x=12.
REQ-039 Drive the march to the left edge -> at o_x=0 the next step gives o_y=16, o_dir=1; the following edge hit gives o_y=24, then o_landed=1 and outputs stay frozen under further ticks.
REQ-040 enable=0 after 1 tick for 500 clocks with ticks present -> no o_step; after re-enable, o_step after exactly 2 more ticks.
REQ-041 i_reset=0 pulsed during WAIT and during STEP -> next cycle o_x=8, o_y=0, o_dir=1, o_step=0, o_landed=0.
REQ-042 alive changed from 1 to 5 mid-WAIT -> current interval remains 3 ticks; the next interval is 7 ticks.
